// File: rtl/mux_pattern_gen_pkg.sv
// -----------------------------------------------------------------------------
// mux_tb_pkg
// Shared definitions for the 2:1 mux stimulus/checking stages:
//   - state_e      : pattern generator FSM encoding
//   - PAT_W        : width of the pattern code / pattern index
//   - A/B/S_POS    : bit positions of a, b and s within the pattern code
//   - HOLD_W       : width of the per-pattern hold counter
//   - mux_expect() : reference 2:1 mux function, also used downstream
// -----------------------------------------------------------------------------
package mux_tb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int PAT_W  = 3;
    localparam int A_POS  = 0;
    localparam int B_POS  = 1;
    localparam int S_POS  = 2;
    localparam int HOLD_W = 8;

    // s=0 selects a, s=1 selects b.
    function automatic logic mux_expect(input logic a, input logic b, input logic s);
        return (a & ~s) | (b & s);
    endfunction

endpackage

// File: rtl/mux_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// mux_pattern_gen_if
// Pattern bus between the generator (master) and the mux datapath / checker
// (slave).
//   pat_a, pat_b, pat_s : mux inputs for the current pattern
//   pat_valid           : pattern is valid
//   pat_ready           : downstream accepts the pattern (slave -> master)
//   exp_x               : expected mux output for the current pattern
//   pat_idx             : index of the current pattern
// -----------------------------------------------------------------------------
interface mux_pattern_gen_if;
    import mux_tb_pkg::*;

    logic             pat_a;
    logic             pat_b;
    logic             pat_s;
    logic             pat_valid;
    logic             pat_ready;
    logic             exp_x;
    logic [PAT_W-1:0] pat_idx;

    modport master (
        output pat_a, pat_b, pat_s, pat_valid, exp_x, pat_idx,
        input  pat_ready
    );

    modport slave (
        input  pat_a, pat_b, pat_s, pat_valid, exp_x, pat_idx,
        output pat_ready
    );

endinterface

// File: rtl/mux_hold_counter.sv
// -----------------------------------------------------------------------------
// mux_hold_counter
// Loadable down-counter that saturates at zero.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one when non-zero
//   zero      : count is zero
// -----------------------------------------------------------------------------
module mux_hold_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: flops are updated with <= so every register samples the
    // pre-edge values of its neighbours, matching real hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_pattern_gen.sv
// -----------------------------------------------------------------------------
// mux_pattern_gen
// Stimulus stage for the 2:1 mux datapath. A start pulse sweeps pat_idx from
// 0 to LAST_IDX; each pattern is offered with a valid/ready handshake and, once
// accepted, held for HOLD_CYC cycles before the next one is offered.
//   clk, rst : clock, synchronous active-high reset
//   start    : single-cycle sweep request (ignored while busy and when done)
//   busy     : sweep in progress
//   done     : one-cycle pulse at sweep completion
//   pat      : pattern bus (master side), see mux_pattern_gen_if
// Build option:
//   MUX_PATGEN_GRAY_EN : pattern code is the Gray code of pat_idx instead of
//                        pat_idx itself; timing and handshake are unchanged.
// -----------------------------------------------------------------------------
module mux_pattern_gen
    import mux_tb_pkg::*;
#(
    parameter int HOLD_CYC = 2,
    parameter int LAST_IDX = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    mux_pattern_gen_if.master       pat
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);
    localparam logic [PAT_W-1:0]  LAST      = PAT_W'(LAST_IDX);

    function automatic logic [PAT_W-1:0] pat_code(input logic [PAT_W-1:0] idx);
`ifdef MUX_PATGEN_GRAY_EN
        return idx ^ (idx >> 1);
`else
        return idx;
`endif
    endfunction

    state_e           state_q, state_d;
    logic [PAT_W-1:0] idx_q, idx_d;
    logic [PAT_W-1:0] code_q, code_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_load, cnt_dec, cnt_zero;

    mux_hold_counter #(.W(HOLD_W)) u_hold_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (HOLD_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        code_d   = code_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    idx_d   = '0;
                    code_d  = pat_code('0);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_DRIVE: begin
                // Counter loads HOLD_CYC-1 so that exactly HOLD_CYC cycles
                // are spent in HOLD (the zero cycle included).
                if (valid_q && pat.pat_ready) begin
                    state_d  = ST_HOLD;
                    valid_d  = 1'b0;
                    cnt_load = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (idx_q == LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRIVE;
                    idx_d   = idx_q + PAT_W'(1);
                    code_d  = pat_code(idx_q + PAT_W'(1));
                    valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                // Pattern outputs keep their last value; start is not
                // looked at in this cycle.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: only a handful of control flops here, so all of them take the
    // synchronous reset; there is no storage array that would need to be
    // left out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pat.pat_a     = code_q[A_POS];
    assign pat.pat_b     = code_q[B_POS];
    assign pat.pat_s     = code_q[S_POS];
    assign pat.pat_valid = valid_q;
    assign pat.pat_idx   = idx_q;
    // Only output that is not a flop: decoded from the registered pattern.
    assign pat.exp_x     = mux_expect(code_q[A_POS], code_q[B_POS], code_q[S_POS]);
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: doc/mux_pattern_gen.md
Name: mux_pattern_gen

Overview:
Upstream stimulus stage for the 2:1 mux datapath. On a start pulse it steps an index through all eight (a, b, s) input combinations and presents each one on registered outputs with a valid/ready handshake. Each pattern is held stable for a programmable number of cycles. It also presents the expected mux output so the downstream stage can self-check.

Parameters:
- HOLD_CYC, 2, cycles each accepted pattern is held before advancing (legal range 1..255).
- LAST_IDX, 7, final index of the sweep (legal range 0..7).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle request to begin a sweep
- pat_ready  in  1  downstream ready to accept the current pattern
- pat_a  out  1  mux data input a
- pat_b  out  1  mux data input b
- pat_s  out  1  mux select
- pat_valid  out  1  pattern on pat_a/b/s is valid
- exp_x  out  1  expected mux output: (pat_a & ~pat_s) | (pat_b & pat_s)
- pat_idx  out  3  index of the current pattern
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when the sweep completes

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state IDLE, pat_idx=0, pat_a/b/s=0, pat_valid=0, busy=0, done=0, hold counter=0. exp_x therefore reads 0.
- Pattern mapping: code = f(pat_idx), with pat_a=code[0], pat_b=code[1], pat_s=code[2]. Without the optional feature, f is the identity.
- All outputs are registered except exp_x. exp_x is combinational from the registered pattern bits only.
- FSM states: IDLE, DRIVE, HOLD, DONE.
- IDLE:
  - start=1 sampled → next cycle: DRIVE, pat_idx=0, pattern=f(0), pat_valid=1, busy=1.
  - Latency from start to pat_valid is 1 cycle.
- DRIVE:
  - pat_valid=1 and the pattern is stable.
  - pat_valid & pat_ready at an edge → HOLD, counter=HOLD_CYC-1, pat_valid=0.
  - pat_ready low → remain in DRIVE indefinitely with the pattern unchanged.
- HOLD:
  - Pattern stays stable; counter decrements each cycle.
  - Counter==0 and pat_idx==LAST_IDX → DONE, busy=0, done=1.
  - Counter==0 otherwise → DRIVE, pat_idx+1, new pattern, pat_valid=1.
  - With HOLD_CYC=1 the block spends exactly one cycle in HOLD.
- DONE: done is high for exactly one cycle, then IDLE. The pattern outputs keep their last value until the next start.
- start is ignored while busy=1 and during the DONE cycle.
- pat_idx never wraps. The sweep ends at LAST_IDX; LAST_IDX=0 gives a single-pattern sweep.
- rst asserted mid-sweep → all reset values at the next edge, no done pulse.
- rst and start high in the same cycle → rst wins; start is lost.
- Per pattern with pat_ready tied high: 1 DRIVE cycle + HOLD_CYC HOLD cycles. A full default sweep is therefore 8*(1+2)=24 cycles from the first pat_valid to done.

Optional Feature:
- MUX_PATGEN_GRAY_EN defined: f(idx) = idx ^ (idx >> 1) (Gray order). Consecutive patterns differ in exactly one of a/b/s.
  - Default sequence of (s,b,a): 000,001,011,010,110,111,101,100.
- Not defined: f is the identity (binary order 000..111).
- pat_idx, the handshake and all timing are identical in both builds.

Decomposition:
- Shared package mux_tb_pkg:
  - FSM state encoding (IDLE=0, DRIVE=1, HOLD=2, DONE=3)
  - PAT_W=3 and the bit positions of a/b/s within the code
  - a function for the expected mux output, reused by the downstream checker
- One sub-module, mux_hold_counter: loadable down-counter with a zero flag.
- The Gray/binary mapping stays inline.

Test Plan:
- Reset, then start=1 for one cycle, pat_ready=1, defaults → exactly 8 pat_valid windows; (s,b,a) sequence 000..111; exp_x sequence 0,1,0,1,0,0,1,1; done pulses 24 cycles after the first pat_valid.
- pat_ready held low 5 cycles at idx=3 → pat_valid stays high, (s,b,a)=011 and exp_x=1 stable for all 5 cycles; the sweep resumes when ready rises.
- HOLD_CYC=1, LAST_IDX=0 → one pattern (000), done 2 cycles after pat_valid, busy returns to 0.
- start re-pulsed at idx=4 → ignored; sweep completes normally with a single done pulse.
- rst raised at idx=5 during HOLD → next edge: all outputs 0, state IDLE, no done; a fresh start restarts at idx 0.
- Build with MUX_PATGEN_GRAY_EN → (s,b,a) sequence 000,001,011,010,110,111,101,100; each step changes exactly one bit; pat_idx still 0..7.
